// File: rtl/pong_pkg.sv
// Shared constants, report layout and axis helper for the pong controller input path.
package pong_pkg;

  localparam int SCREEN_H       = 480;
  localparam int PADDLE_H       = 64;
  localparam int DEAD           = 16;
  localparam int SPEED_SHIFT    = 4;
  localparam int DPAD_SPEED     = 4;
  localparam int TIMEOUT_FRAMES = 60;

  localparam int POS_MAX   = SCREEN_H - PADDLE_H;
  localparam int POS_RESET = POS_MAX / 2;

  localparam int BYTE_ID   = 0;
  localparam int BYTE_BTN  = 1;
  localparam int BYTE_AXIS = 2;
  localparam int BYTE_SEQ  = 3;

  localparam int BTN_SERVE = 0;
  localparam int BTN_UP    = 2;
  localparam int BTN_DOWN  = 3;

  localparam logic [7:0] ID_LEFT  = 8'h00;
  localparam logic [7:0] ID_RIGHT = 8'h01;

  localparam logic signed [11:0] DEAD_S = 12'(DEAD);

  // Only the first four bytes of a report carry anything we act on.
  typedef struct packed {
    logic [7:0] seq;
    logic [7:0] axis;
    logic [7:0] buttons;
    logic [7:0] id;
  } report_t;

  // Centre the unsigned axis and apply the dead zone before scaling down.
  function automatic logic signed [11:0] analogVelocity(input logic [7:0] axis);
    logic signed [11:0] centred;
    centred = $signed({4'b0000, axis}) - 12'sd128;
    if (centred > -DEAD_S && centred < DEAD_S) begin
      return 12'sd0;
    end
    return centred >>> SPEED_SHIFT;
  endfunction

endpackage

// File: rtl/paddle_axis.sv
// One player's paddle: velocity, clamped position, serve edge detect and connection state.
// Sequence timeout tracking is compiled in only when PADDLE_TIMEOUT_EN is defined.
module paddle_axis
  import pong_pkg::*;
#(
  parameter logic [7:0] PORT_ID = ID_LEFT
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       tick_i,
  input  logic [7:0] id_i,
  input  logic [7:0] buttons_i,
  input  logic [7:0] axis_i,
  input  logic [7:0] seq_i,
  output logic [9:0] pos_o,
  output logic       serve_o,
  output logic       conn_o
);

  localparam logic [9:0]        POS_MAX_V   = 10'(POS_MAX);
  localparam logic [9:0]        POS_RESET_V = 10'(POS_RESET);
  localparam logic signed [11:0] POS_MAX_S  = 12'(POS_MAX);
  localparam logic signed [11:0] DPAD_S     = 12'(DPAD_SPEED);

  logic [9:0]         posQ, posD;
  logic               serveQ, serveD;
  logic               connQ, connD;
  logic               prevServeQ, prevServeD;
  logic               valid, active, up, down;
  logic signed [11:0] vel, sum;

`ifdef PADDLE_TIMEOUT_EN
  localparam logic [6:0] TIMEOUT_V = 7'(TIMEOUT_FRAMES);
  logic [7:0] lastSeqQ, lastSeqD;
  logic [6:0] missQ, missD;
`else
  logic unusedSeq;
  assign unusedSeq = ^seq_i;
`endif

  // The connection decision is made first so a reconnecting report moves the paddle on the same tick.
  always_comb begin
    posD       = posQ;
    serveD     = 1'b0;
    connD      = connQ;
    prevServeD = prevServeQ;
    sum        = 12'sd0;
    valid      = (id_i == PORT_ID);
    up         = buttons_i[BTN_UP];
    down       = buttons_i[BTN_DOWN];
`ifdef PADDLE_TIMEOUT_EN
    lastSeqD   = lastSeqQ;
    missD      = missQ;
    if (tick_i) begin
      if (valid && seq_i != lastSeqQ) begin
        missD    = 7'd0;
        connD    = 1'b1;
        lastSeqD = seq_i;
      end else begin
        missD = (missQ >= TIMEOUT_V - 7'd1) ? TIMEOUT_V : missQ + 7'd1;
        if (missD == TIMEOUT_V) begin
          connD = 1'b0;
        end
      end
    end
`else
    connD      = 1'b1;
`endif
    active = tick_i && valid && connD;

    vel = analogVelocity(axis_i);
    if (up && !down) begin
      vel = -DPAD_S;
    end else if (down && !up) begin
      vel = DPAD_S;
    end else if (up && down) begin
      vel = 12'sd0;
    end

    // Signed 12-bit sum leaves headroom on both sides, so clamping never sees a wrap.
    if (active) begin
      sum = $signed({2'b00, posQ}) + vel;
      if (sum < 12'sd0) begin
        posD = 10'd0;
      end else if (sum > POS_MAX_S) begin
        posD = POS_MAX_V;
      end else begin
        posD = sum[9:0];
      end
      serveD = buttons_i[BTN_SERVE] && !prevServeQ;
    end

    if (tick_i && valid) begin
      prevServeD = buttons_i[BTN_SERVE];
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      posQ       <= POS_RESET_V;
      serveQ     <= 1'b0;
      connQ      <= 1'b0;
      prevServeQ <= 1'b0;
`ifdef PADDLE_TIMEOUT_EN
      lastSeqQ   <= 8'd0;
      missQ      <= TIMEOUT_V;
`endif
    end else begin
      posQ       <= posD;
      serveQ     <= serveD;
      connQ      <= connD;
      prevServeQ <= prevServeD;
`ifdef PADDLE_TIMEOUT_EN
      lastSeqQ   <= lastSeqD;
      missQ      <= missD;
`endif
    end
  end

  assign pos_o   = posQ;
  assign serve_o = serveQ;
  assign conn_o  = connQ;

endmodule

// File: rtl/paddle_input.sv
// Turns the two gamepad report registers into paddle positions, serve pulses and connection flags.
// Define PADDLE_TIMEOUT_EN to enable per-player sequence timeout tracking.
module paddle_input
  import pong_pkg::*;
(
  input  logic         clk,
  input  logic         resetn,
  input  logic [127:0] ldata,
  input  logic [127:0] rdata,
  input  logic         frame_tick,
  output logic [9:0]   lpos,
  output logic [9:0]   rpos,
  output logic         lserve,
  output logic         rserve,
  output logic         lconn,
  output logic         rconn
);

  report_t leftReport, rightReport;
  logic    unusedReportBits;

  assign leftReport       = ldata[31:0];
  assign rightReport      = rdata[31:0];
  assign unusedReportBits = ^{ldata[127:32], rdata[127:32]};

  paddle_axis #(.PORT_ID(ID_LEFT)) leftAxis (
    .clk       (clk),
    .resetn    (resetn),
    .tick_i    (frame_tick),
    .id_i      (leftReport.id),
    .buttons_i (leftReport.buttons),
    .axis_i    (leftReport.axis),
    .seq_i     (leftReport.seq),
    .pos_o     (lpos),
    .serve_o   (lserve),
    .conn_o    (lconn)
  );

  paddle_axis #(.PORT_ID(ID_RIGHT)) rightAxis (
    .clk       (clk),
    .resetn    (resetn),
    .tick_i    (frame_tick),
    .id_i      (rightReport.id),
    .buttons_i (rightReport.buttons),
    .axis_i    (rightReport.axis),
    .seq_i     (rightReport.seq),
    .pos_o     (rpos),
    .serve_o   (rserve),
    .conn_o    (rconn)
  );

endmodule

// File: doc/paddle_input.md
# paddle_input

Converts the two 128-bit gamepad report registers produced by the SPI report receiver into pong game controls. Once per video frame it samples each player's report and integrates the analog Y axis or the d-pad into a clamped paddle position. It also emits a one-cycle serve pulse on each serve-button press and tracks per-player connection status from the report sequence byte. It sits between the report receiver and the pong game logic/renderer, in the `clk` domain.

## Interface
- `SCREEN_H`, 480, visible lines.
- `PADDLE_H`, 64, paddle height in lines; max position = `SCREEN_H-PADDLE_H`.
- `DEAD`, 16, analog dead zone half-width.
- `SPEED_SHIFT`, 4, analog velocity = centred axis >>> `SPEED_SHIFT`.
- `DPAD_SPEED`, 4, lines/frame for d-pad.
- `TIMEOUT_FRAMES`, 60, unchanged-sequence frames before disconnect.
- `clk` in 1 system clock.
- `resetn` in 1 reset, synchronous, active-low.
- `ldata` in 128 left-player report, byte k = bits [8k+7:8k].
- `rdata` in 128 right-player report, same layout.
- `frame_tick` in 1 one-cycle pulse per frame (vsync start).
- `lpos`, `rpos` out 10 paddle top line.
- `lserve`, `rserve` out 1 one-cycle serve pulse.
- `lconn`, `rconn` out 1 player connected.

## Operation
- Report layout: byte0 = port ID (left 0x00, right 0x01); byte1 = buttons (bit0 serve, bit2 up, bit3 down); byte2 = Y axis, unsigned, centre 0x80; byte3 = sequence number, incremented by firmware per report.
- Sampling: reports are read only on `frame_tick`. The receiver updates all 128 bits at once, so a sample is always coherent.
- Report valid: byte0 equals the expected ID. An invalid report is treated as unchanged, with buttons and axis ignored; the previous button state is kept.
- Velocity (signed, 12-bit internal):
  - a = byte2 − 128.
  - |a| < `DEAD` → v = 0; otherwise v = a >>> `SPEED_SHIFT`, so v ranges −8..+7 with defaults.
  - D-pad overrides analog: up only → v = −`DPAD_SPEED`; down only → +`DPAD_SPEED`; both → 0.
- Position update: pos ← clamp(pos + v, 0, `SCREEN_H-PADDLE_H`), computed in signed 12-bit, so there is no wrap-around.
- Serve: on a tick, valid report, connected, bit0 = 1 and the previous sampled bit0 = 0 → one-cycle pulse. Holding the button produces no repeat.
- Connection (when compiled in):
  - Valid report with seq ≠ last seq → miss counter = 0, conn = 1, last seq ← seq.
  - Otherwise → miss counter increments, saturating at `TIMEOUT_FRAMES`; on reaching it, conn = 0.
  - While conn = 0: v forced to 0 (position frozen) and serve suppressed. The state that reconnects takes effect on the same tick it is computed.
- Players are fully independent.

## Timing
- Reset values: `lpos` = `rpos` = 208 (`(SCREEN_H-PADDLE_H)/2`); serve outputs 0; conn outputs 0; miss counters = `TIMEOUT_FRAMES`; last seq = 0; previous buttons = 0.
- Latency: outputs update on the clk edge after the cycle with `frame_tick` = 1 (1 cycle).
- Serve pulses are exactly 1 cycle wide.
- Outputs are stable between ticks.
- `ldata`/`rdata` changing in the tick cycle: the value present in that cycle is used.
- Consecutive-cycle ticks are each processed.
- `resetn` low during a tick: reset wins; the tick is discarded.

## Configuration
- `PADDLE_TIMEOUT_EN` defined: sequence tracking, miss counters and conn logic as above.
- Not defined:
  - No counters and no seq registers.
  - conn outputs are 0 during reset and 1 from the first cycle after reset.
  - A valid ID byte alone gates the update.

## Structure
- Package `pong_pkg`: report byte offsets, button bit indices, port ID constants, default screen/paddle constants.
- Sub-module `paddle_axis`, instantiated twice: one player's velocity, clamp, serve edge detect and timeout. The top level only slices reports and wires the two instances.

## Test plan
- Reset → `lpos`=`rpos`=208, conn outputs = 0, serve outputs = 0; hold ticks with reports all-zero → unchanged (with macro).
- `ldata` byte2=0xC0, seq incremented each tick, 3 ticks → `lconn`=1 after first tick; `lpos` 212, 216, 220.
- Axis 0xFF for 40 ticks → `lpos` saturates at 416; then axis 0x00 → decrements by 8 per tick down to 0 and stays at 0.
- Axis 0x8F → no movement; up with axis 0xFF → −4 per tick; up+down → 0.
- `rdata` byte0=0x01, bit0 0→1 held across 5 ticks → exactly one `rserve` pulse, 1 cycle after the tick; byte0=0x00 on `rdata` → ignored.
- Seq frozen for 60 ticks → `lconn` falls on the 60th unchanged tick, position frozen with axis 0xFF; seq changes → `lconn`=1 and movement resumes on that tick.
